// File: rtl/arith_sequencer.sv
// Control sequencer for the arithmetic machine: fetch/decode/execute/writeback
// over a req/valid instruction port, owning every datapath enable.
module arith_sequencer #(
    parameter int CNT_W         = 16,
    parameter int FETCH_TIMEOUT = 8
) (
    input  logic             clock,
    input  logic             reset,
    output logic             inst_req,
    input  logic             inst_valid,
    input  logic [31:0]      inst,
    output logic             pc_en,
    output logic             rf_wr_en,
    output logic [4:0]       rd_sel,
    output logic [4:0]       rs_sel,
    output logic [4:0]       rt_sel,
    output logic [31:0]      imm,
    output logic             alu_src2,
    output logic [2:0]       alu_op,
    output logic             busy,
    output logic             except,
    output logic [CNT_W-1:0] retired
);

    localparam int TO_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_EXCEPT
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    logic        dec_legal;
    logic        dec_itype;
    logic [2:0]  dec_op;
    logic [4:0]  dec_rd;
    logic [31:0] dec_imm;

    // Instruction classification is purely a function of IR.
    always_comb begin
        dec_legal = 1'b0;
        dec_itype = 1'b0;
        dec_op    = 3'd0;
        dec_rd    = ir_q[15:11];
        dec_imm   = '0;
        case (ir_q[31:26])
            6'h00: begin
                if (ir_q[10:6] == 5'd0) begin
                    dec_legal = 1'b1;
                    case (ir_q[5:0])
                        6'h20:   dec_op = 3'd2;
                        6'h22:   dec_op = 3'd3;
                        6'h24:   dec_op = 3'd4;
                        6'h25:   dec_op = 3'd5;
                        6'h26:   dec_op = 3'd7;
                        6'h27:   dec_op = 3'd6;
                        default: dec_legal = 1'b0;
                    endcase
                end
            end
            6'h08, 6'h0c, 6'h0d, 6'h0e: begin
                dec_legal = 1'b1;
                dec_itype = 1'b1;
                dec_rd    = ir_q[20:16];
                dec_imm   = {16'h0000, ir_q[15:0]};
                case (ir_q[31:26])
                    6'h08: begin
                        dec_op  = 3'd2;
                        dec_imm = {{16{ir_q[15]}}, ir_q[15:0]};
                    end
                    6'h0c:   dec_op = 3'd4;
                    6'h0d:   dec_op = 3'd5;
                    default: dec_op = 3'd7;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        cnt_d    = cnt_q;
        ret_d    = ret_q;
        inst_req = 1'b0;
        pc_en    = 1'b0;
        rf_wr_en = 1'b0;
        rd_sel   = '0;
        rs_sel   = '0;
        rt_sel   = '0;
        imm      = '0;
        alu_src2 = 1'b0;
        alu_op   = '0;
        busy     = 1'b0;
        except   = 1'b0;

        // Datapath controls are presented in EXEC and held unchanged through WB.
        if (state_q == S_EXEC || state_q == S_WB) begin
            rd_sel   = dec_rd;
            rs_sel   = ir_q[25:21];
            rt_sel   = ir_q[20:16];
            imm      = dec_imm;
            alu_src2 = dec_itype;
            alu_op   = dec_op;
        end

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                busy     = 1'b1;
                inst_req = 1'b1;
                if (inst_valid) begin
                    ir_d    = inst;
                    cnt_d   = '0;
                    state_d = S_DECODE;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = '0;
                    state_d = S_EXCEPT;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_DECODE: begin
                busy    = 1'b1;
                state_d = dec_legal ? S_EXEC : S_EXCEPT;
            end
            S_EXEC: begin
                busy    = 1'b1;
                state_d = S_WB;
            end
            S_WB: begin
                busy     = 1'b1;
                pc_en    = 1'b1;
                rf_wr_en = (dec_rd != 5'd0);
                ret_d    = ret_q + CNT_W'(1);
                state_d  = S_FETCH;
            end
            S_EXCEPT: except = 1'b1;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
        end
    end

    assign retired = ret_q;

endmodule

// File: tb/tb_arith_sequencer.sv
// Scoreboard bench for arith_sequencer: expected writeback controls are queued
// when an instruction is handed over and compared at the WB cycle.
module tb_arith_sequencer;

    logic        clock;
    logic        reset;
    logic        inst_req;
    logic        inst_valid;
    logic [31:0] inst;
    logic        pc_en;
    logic        rf_wr_en;
    logic [4:0]  rd_sel;
    logic [4:0]  rs_sel;
    logic [4:0]  rt_sel;
    logic [31:0] imm;
    logic        alu_src2;
    logic [2:0]  alu_op;
    logic        busy;
    logic        except;
    logic [15:0] retired;

    arith_sequencer #(.CNT_W(16), .FETCH_TIMEOUT(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .inst_req   (inst_req),
        .inst_valid (inst_valid),
        .inst       (inst),
        .pc_en      (pc_en),
        .rf_wr_en   (rf_wr_en),
        .rd_sel     (rd_sel),
        .rs_sel     (rs_sel),
        .rt_sel     (rt_sel),
        .imm        (imm),
        .alu_src2   (alu_src2),
        .alu_op     (alu_op),
        .busy       (busy),
        .except     (except),
        .retired    (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] imm;
        logic [2:0]  op;
        logic        src2;
        logic        wr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] exp_ret;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] k);
        return {op, rs, rt, k};
    endfunction

    function automatic exp_t exp_of(input logic [31:0] w);
        exp_t e;
        e.rs = w[25:21];
        e.rt = w[20:16];
        if (w[31:26] == 6'h00) begin
            e.rd   = w[15:11];
            e.imm  = 32'h0;
            e.src2 = 1'b0;
            case (w[5:0])
                6'h20:   e.op = 3'd2;
                6'h22:   e.op = 3'd3;
                6'h24:   e.op = 3'd4;
                6'h25:   e.op = 3'd5;
                6'h26:   e.op = 3'd7;
                default: e.op = 3'd6;
            endcase
        end else begin
            e.rd   = w[20:16];
            e.src2 = 1'b1;
            e.imm  = (w[31:26] == 6'h08 && w[15]) ? {16'hFFFF, w[15:0]} : {16'h0000, w[15:0]};
            case (w[31:26])
                6'h08:   e.op = 3'd2;
                6'h0c:   e.op = 3'd4;
                6'h0d:   e.op = 3'd5;
                default: e.op = 3'd7;
            endcase
        end
        e.wr = (e.rd != 5'd0);
        return e;
    endfunction

    // Writeback monitor: every WB pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (reset) begin
            if (rf_wr_en) check("wr_outside_wb", 32'(pc_en), 32'd1);
            if (pc_en) begin
                check("req_with_pc_en", 32'(inst_req), 32'd0);
                check("sb_nonempty_at_wb", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("wb_rd_sel",   32'(rd_sel),   32'(mon_e.rd));
                    check("wb_rs_sel",   32'(rs_sel),   32'(mon_e.rs));
                    check("wb_rt_sel",   32'(rt_sel),   32'(mon_e.rt));
                    check("wb_imm",      imm,           mon_e.imm);
                    check("wb_alu_op",   32'(alu_op),   32'(mon_e.op));
                    check("wb_alu_src2", 32'(alu_src2), 32'(mon_e.src2));
                    check("wb_rf_wr_en", 32'(rf_wr_en), 32'(mon_e.wr));
                    check("wb_retired",  32'(retired),  32'(exp_ret));
                    exp_ret = exp_ret + 16'd1;
                end
            end
        end
    end

    task automatic fetch_word(input logic [31:0] w, input int hold);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (inst_req) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("req_seen", 32'(got), 32'd1);
        if (got) begin
            repeat (hold) @(negedge clock);
            inst_valid = 1'b1;
            inst       = w;
            @(negedge clock);
            inst_valid = 1'b0;
            inst       = $urandom();
        end
    endtask

    task automatic issue(input logic [31:0] w, input int hold);
        sb.push_back(exp_of(w));
        fetch_word(w, hold);
    endtask

    task automatic do_reset();
        @(negedge clock);
        check("sb_empty_at_reset", 32'(sb.size()), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_busy",    32'(busy),     32'd0);
        check("rst_except",  32'(except),   32'd0);
        check("rst_retired", 32'(retired),  32'd0);
        repeat (3) @(negedge clock);
        exp_ret = 16'd0;
        reset   = 1'b1;
    endtask

    logic [5:0] rfn [6];
    logic [5:0] iop [4];

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        exp_ret    = 16'd0;
        reset      = 1'b0;
        inst_valid = 1'b0;
        inst       = 32'h0;
        rfn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
        iop = '{6'h08, 6'h0c, 6'h0d, 6'h0e};

        // Reset held three cycles; inst_valid asserted meanwhile must be ignored.
        @(negedge clock);
        inst_valid = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_inst_req", 32'(inst_req), 32'd0);
        check("reset_pc_en",    32'(pc_en),    32'd0);
        check("reset_rf_wr_en", 32'(rf_wr_en), 32'd0);
        check("reset_busy",     32'(busy),     32'd0);
        check("reset_except",   32'(except),   32'd0);
        check("reset_alu_op",   32'(alu_op),   32'd0);
        check("reset_imm",      imm,           32'd0);
        check("reset_retired",  32'(retired),  32'd0);
        inst_valid = 1'b0;
        reset      = 1'b1;

        // add $8,$9,$10: FETCH at cycle 1, WB at cycle 4.
        @(negedge clock);
        check("fetch_cycle1", 32'(inst_req), 32'd1);
        check("fetch_ctrl_zero", 32'(alu_op), 32'd0);
        sb.push_back(exp_of(32'h012A4020));
        inst_valid = 1'b1;
        inst       = 32'h012A4020;
        @(negedge clock);
        inst_valid = 1'b0;
        check("decode_no_req", 32'(inst_req), 32'd0);
        @(negedge clock);
        check("exec_alu_op", 32'(alu_op), 32'd2);
        check("exec_no_pc_en", 32'(pc_en), 32'd0);
        @(negedge clock);
        check("wb_cycle4_pc_en", 32'(pc_en), 32'd1);
        @(negedge clock);
        check("retired_after_first", 32'(retired), 32'd1);

        // Immediate forms and a write to $0.
        issue(32'h2128FFFF, 0);
        issue(32'h3528FFFF, 0);
        issue(32'h00220020, 1);
        issue(itype(6'h0c, 5'd3, 5'd4, 16'h8001), 0);
        issue(itype(6'h0e, 5'd5, 5'd6, 16'hA5A5), 2);

        // Seven idle fetch cycles still retires.
        issue(rtype(6'h27, 5'd1, 5'd2, 5'd3), 7);

        // Random legal traffic.
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 0)
                issue(rtype(rfn[$urandom_range(0, 5)], 5'($urandom_range(0, 31)),
                            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))),
                      int'($urandom_range(0, 3)));
            else
                issue(itype(iop[$urandom_range(0, 3)], 5'($urandom_range(0, 31)),
                            5'($urandom_range(0, 31)), 16'($urandom())),
                      int'($urandom_range(0, 3)));
        end
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clock);

        // Illegal lw: exception the cycle after DECODE, sticky for 20 cycles.
        fetch_word(32'h8D280000, 0);
        @(negedge clock);
        check("lw_except",   32'(except),   32'd1);
        check("lw_busy",     32'(busy),     32'd0);
        check("lw_inst_req", 32'(inst_req), 32'd0);
        repeat (20) @(negedge clock);
        check("lw_except_sticky", 32'(except), 32'd1);
        do_reset();

        // R-type with nonzero shamt is illegal.
        fetch_word(32'h012A4060, 0);
        @(negedge clock);
        check("shamt_except", 32'(except), 32'd1);
        do_reset();

        // Eight idle fetch cycles trips the timeout.
        fetch_word(32'h012A4020, 8);
        check("timeout_except", 32'(except), 32'd1);
        check("timeout_retired", 32'(retired), 32'd0);
        do_reset();

        // Reset during EXEC of a sub aborts without a write.
        fetch_word(rtype(6'h22, 5'd7, 5'd8, 5'd9), 0);
        @(negedge clock);
        check("sub_in_exec", 32'(alu_op), 32'd3);
        #2 reset = 1'b0;
        #1;
        check("abort_alu_op", 32'(alu_op), 32'd0);
        check("abort_busy",   32'(busy),   32'd0);
        repeat (3) @(negedge clock);
        exp_ret = 16'd0;
        reset   = 1'b1;
        check("abort_retired", 32'(retired), 32'd0);
        issue(rtype(6'h22, 5'd7, 5'd8, 5'd9), 0);
        issue(rtype(6'h26, 5'd10, 5'd11, 5'd12), 1);

        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clock);
        check("sb_drain", 32'(sb.size()), 32'd0);
        @(negedge clock);
        check("final_retired", 32'(retired), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
